// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pc_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // PC of the first fetch after reset (boot ROM vector)
  localparam logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000;

  // Byte distance between sequential instruction words
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    FS_IDLE    = 3'd0,
    FS_REQ     = 3'd1,
    FS_RESP    = 3'd2,
    FS_HOLD    = 3'd3,
    FS_DISCARD = 3'd4
  } fetch_state_e;

  // Sequential successor of a PC; wraps modulo 2^32
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return XLEN'(pc + PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_redirect_buf.sv
// Holds a branch/jump redirect resolved before its delay slot was handed
// to Decode, and selects the PC that follows the word being handed over.
module redirect_buf
  import fetch_pc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic            flush_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic [XLEN-1:0] pc_f_i,
  output logic            pend_o,
  output logic [XLEN-1:0] next_pc_o
);

  logic            pend_q, pend_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  // Flush and hand-off both retire the pending redirect; otherwise a new one is captured
  always_comb begin
    pend_d = pend_q;
    tgt_d  = tgt_q;
    if (flush_i || clear_i) begin
      pend_d = 1'b0;
    end else if (load_i) begin
      pend_d = 1'b1;
      tgt_d  = redirect_target_i;
    end
  end

  // Pending-redirect state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end

  // Buffered redirect first, then a live one, else fall through
  assign next_pc_o = pend_q           ? tgt_q :
                     redirect_valid_i ? redirect_target_i :
                                        seq_pc(pc_f_i);

  assign pend_o = pend_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: issues one instruction-SRAM request at a time,
// holds the returned word for Decode and steers the PC through branch delay
// slots, buffered redirects and exception flushes.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            excp_valid,
  input  logic [XLEN-1:0] excp_pc,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic [XLEN-1:0] instF,
  output logic [XLEN-1:0] pcF,
  output logic            validF,
  output logic            ds_flagF
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pcF_q;
  logic [XLEN-1:0] instF_q;
  logic            validF_q;

  logic            fire;
  logic            rsp_in_flight;
  logic            redir_pend;
  logic [XLEN-1:0] next_pc;

  // Hand-off to Decode; a flush in the same cycle cancels it
  assign fire = validF_q & ~stallF & ~excp_valid;

  // A response is still owed by memory after this cycle, so a flush must
  // drop it rather than start a new request on top of it
  assign rsp_in_flight = (((state_q == FS_RESP) || (state_q == FS_DISCARD)) && !inst_data_ok) ||
                         ((state_q == FS_REQ) && inst_addr_ok);

  redirect_buf u_redirect_buf (
    .clk               (clk),
    .rst               (rst),
    .load_i            (redirect_valid & ~fire),
    .clear_i           (fire),
    .flush_i           (excp_valid),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_f_i            (pcF_q),
    .pend_o            (redir_pend),
    .next_pc_o         (next_pc)
  );

  // Fetch sequencer: request, wait, hold for Decode, drop stale responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FS_IDLE;
      pc_q     <= RESET_PC;
      pcF_q    <= RESET_PC;
      instF_q  <= '0;
      validF_q <= 1'b0;
    end else if (excp_valid) begin
      pc_q     <= excp_pc;
      validF_q <= 1'b0;
      state_q  <= rsp_in_flight ? FS_DISCARD : FS_REQ;
    end else begin
      unique case (state_q)
        FS_IDLE: begin
          state_q <= FS_REQ;
        end
        FS_REQ: begin
          if (inst_addr_ok) begin
            state_q <= FS_RESP;
          end
        end
        FS_RESP: begin
          if (inst_data_ok) begin
            state_q  <= FS_HOLD;
            instF_q  <= inst_rdata;
            pcF_q    <= pc_q;
            validF_q <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (fire) begin
            state_q  <= FS_REQ;
            pc_q     <= next_pc;
            validF_q <= 1'b0;
          end
        end
        FS_DISCARD: begin
          if (inst_data_ok) begin
            state_q <= FS_REQ;
          end
        end
        default: begin
          state_q <= FS_IDLE;
        end
      endcase
    end
  end

  // Request side is decoded from registered state only
  assign inst_req  = (state_q == FS_REQ);
  assign inst_addr = pc_q;

  assign instF    = instF_q;
  assign pcF      = pcF_q;
  assign validF   = validF_q;
  // The word handed over alongside an active redirect is the delay slot
  assign ds_flagF = validF_q & (redir_pend | redirect_valid);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios followed by a randomized run,
// checked against a transaction-level model of the fetch stream.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic [31:0] instF;
  logic [31:0] pcF;
  logic        validF;
  logic        ds_flagF;

  fetch_pc_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stallF          (stallF),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .excp_valid      (excp_valid),
    .excp_pc         (excp_pc),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .instF           (instF),
    .pcF             (pcF),
    .validF          (validF),
    .ds_flagF        (ds_flagF)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder state
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          acc_cnt = 0;
  int          lat_data = 0;
  int          lat_acc = 0;
  bit          rnd = 1'b0;
  logic [31:0] acc_q[$];

  // Reference model: next fetch address, outstanding/held word, pending redirect
  logic [31:0] m_addr = RST_PC;
  logic        m_out = 1'b0;
  logic        m_live = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] m_word_pc = '0;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt = '0;

  int          cyc = 0;
  int          last_fire = 0;
  int          fire_gap = 0;
  int          fire_cnt = 0;
  logic        last_ds = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction SRAM: one outstanding read, configurable accept/data delay
  task automatic mem_drive();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_word(mem_addr);
        mem_busy     = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (inst_req) begin
      if (acc_cnt == 0) begin
        inst_addr_ok = 1'b1;
        mem_busy     = 1'b1;
        mem_addr     = inst_addr;
        acc_q.push_back(inst_addr);
        mem_cnt = rnd ? int'($urandom_range(0, 3)) : lat_data;
        acc_cnt = rnd ? int'($urandom_range(0, 2)) : lat_acc;
      end else begin
        acc_cnt--;
      end
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  task automatic observe();
    logic exp_req;
    logic hand;
    cyc++;
    exp_req = !m_out && !m_ready;
    chk("inst_req", 32'(inst_req), 32'(exp_req));
    if (exp_req) chk("inst_addr", inst_addr, m_addr);
    chk("validF", 32'(validF), 32'(m_ready));
    if (m_ready) begin
      chk("pcF", pcF, m_word_pc);
      chk("instF", instF, mem_word(m_word_pc));
      chk("ds_flagF", 32'(ds_flagF), 32'(m_pend | redirect_valid));
    end else begin
      chk("ds_flagF_idle", 32'(ds_flagF), 32'd0);
    end
    if (inst_data_ok) chk("data_ok_proto", 32'(m_out), 32'd1);

    hand = m_ready && !stallF && !excp_valid;
    if (hand) begin
      fire_gap  = cyc - last_fire;
      last_fire = cyc;
      fire_cnt++;
      last_ds   = ds_flagF;
      m_addr    = m_pend ? m_tgt : (redirect_valid ? redirect_target : m_word_pc + 32'd4);
      m_ready   = 1'b0;
      m_pend    = 1'b0;
    end else if (redirect_valid && !excp_valid) begin
      m_pend = 1'b1;
      m_tgt  = redirect_target;
    end
    if (inst_addr_ok) begin
      m_out     = 1'b1;
      m_live    = 1'b1;
      m_word_pc = m_addr;
    end
    if (inst_data_ok) begin
      m_out = 1'b0;
      if (m_live) m_ready = 1'b1;
    end
    if (excp_valid) begin
      m_addr  = excp_pc;
      m_pend  = 1'b0;
      m_ready = 1'b0;
      m_live  = 1'b0;
    end
  endtask

  task automatic advance();
    @(negedge clk);
    mem_drive();
  endtask

  task automatic apply(input logic st, input logic rv, input logic [31:0] rt,
                       input logic ev, input logic [31:0] ep);
    stallF          = st;
    redirect_valid  = rv;
    redirect_target = rt;
    excp_valid      = ev;
    excp_pc         = ep;
    #1;
    observe();
  endtask

  task automatic step_idle();
    advance();
    apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Leaves the cycle with the word at pc held, inputs not yet applied
  task automatic wait_hold(input logic [31:0] pc, input string tag);
    int n = 0;
    advance();
    while (!(validF && pcF == pc) && n < 40) begin
      apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      advance();
      n++;
    end
    chk(tag, pcF, pc);
  endtask

  task automatic wait_accept(input logic [31:0] addr, input string tag);
    int s = acc_q.size();
    int n = 0;
    while (acc_q.size() == s && n < 40) begin
      step_idle();
      n++;
    end
    chk(tag, acc_q[acc_q.size() - 1], addr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stallF = 1'b0; redirect_valid = 1'b0; excp_valid = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    mem_busy = 1'b0; acc_cnt = 0; lat_acc = 0; lat_data = 0;
    m_addr = RST_PC; m_out = 1'b0; m_live = 1'b0; m_ready = 1'b0; m_pend = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_inst_req", 32'(inst_req), 32'd0);
    chk("rst_inst_addr", inst_addr, RST_PC);
    chk("rst_pcF", pcF, RST_PC);
    chk("rst_instF", instF, 32'd0);
    chk("rst_validF", 32'(validF), 32'd0);
    chk("rst_ds_flagF", 32'(ds_flagF), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int s;
    int fc;

    // Reset release, zero-wait memory: sequential fetch, one word per 3 cycles
    do_reset();
    s = acc_q.size();
    repeat (10) step_idle();
    chk("t1_addr0", acc_q[s], 32'hBFC0_0000);
    chk("t1_addr1", acc_q[s + 1], 32'hBFC0_0004);
    chk("t1_addr2", acc_q[s + 2], 32'hBFC0_0008);
    chk("t1_fires", 32'(fire_cnt), 32'd3);
    chk("t1_rate", 32'(fire_gap), 32'd3);

    // Redirect coincident with hand-off of the word at BFC0_0010
    wait_hold(32'hBFC0_0010, "t2_reach");
    apply(1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0);
    chk("t2_ds", 32'(last_ds), 32'd1);
    lat_data = 4;
    wait_accept(32'hBFC0_0100, "t2_next");

    // Early redirect while the delay slot is still in flight
    advance();
    chk("t3_in_resp", 32'(m_out && !inst_data_ok), 32'd1);
    apply(1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'd0);
    wait_hold(32'hBFC0_0100, "t3_reach");
    apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t3_ds", 32'(last_ds), 32'd1);
    lat_data = 0;
    wait_accept(32'h8000_0000, "t3_next");

    // Five stalled cycles in HOLD, then one hand-off
    wait_hold(32'h8000_0000, "t4_reach");
    s  = acc_q.size();
    fc = fire_cnt;
    apply(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (4) begin
      advance();
      apply(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    chk("t4_pcF", pcF, 32'h8000_0000);
    chk("t4_instF", instF, mem_word(32'h8000_0000));
    chk("t4_validF", 32'(validF), 32'd1);
    chk("t4_noreq", 32'(acc_q.size()), 32'(s));
    step_idle();
    chk("t4_one_fire", 32'(fire_cnt), 32'(fc + 1));
    lat_data = 3;
    wait_accept(32'h8000_0004, "t4_next");

    // Exception during RESP with a pending redirect
    advance();
    apply(1'b0, 1'b1, 32'h1234_0000, 1'b0, 32'd0);
    advance();
    fc = fire_cnt;
    apply(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0380);
    lat_data = 0;
    wait_accept(32'hBFC0_0380, "t5_next");
    chk("t5_no_deliver", 32'(fire_cnt), 32'(fc));
    wait_hold(32'hBFC0_0380, "t5_reach");
    apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t5_pend_clr", 32'(last_ds), 32'd0);

    // Asynchronous reset while a request waits for acceptance
    lat_acc = 4;
    acc_cnt = 4;
    advance();
    apply(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t6_req_before", 32'(inst_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_inst_req", 32'(inst_req), 32'd0);
    chk("t6_inst_addr", inst_addr, RST_PC);
    chk("t6_validF", 32'(validF), 32'd0);
    chk("t6_pcF", pcF, RST_PC);
    chk("t6_instF", instF, 32'd0);
    do_reset();

    // Randomized traffic against the model
    rnd = 1'b1;
    fc  = fire_cnt;
    for (int i = 0; i < 600; i++) begin
      logic st, rv, ev;
      logic [31:0] rt, ep;
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 6) == 0);
      ev = ($urandom_range(0, 24) == 0);
      rt = $urandom;
      ep = ($urandom_range(0, 1) == 0) ? 32'hBFC0_0380 : $urandom;
      advance();
      apply(st, rv, rt, ev, ep);
    end
    chk("rnd_progress", 32'(fire_cnt > fc + 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
